// File: rtl/cpu_boot_ctrl_pkg.sv
// Shared constants and state encoding for the CPU boot/run sequencer.
package cpu_boot_ctrl_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_IMEM_DEPTH = 32;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SEED = 3'd1,
      ST_LOAD = 3'd2,
      ST_RUN  = 3'd3,
      ST_HALT = 3'd4
   } state_t;

endpackage

// File: rtl/cpu_boot_ctrl_run_counter.sv
// Loadable saturating counter with a terminal-count compare.
// Used as the RUN cycle timer and as the register-seed index.
module boot_run_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             inc,
   input  logic [CNT_W-1:0] term,
   output logic [CNT_W-1:0] count,
   output logic             at_term
);

   // A saturated count also counts as terminal.
   // Without this, a term value beyond the counter range would never be reached.
   assign at_term = (count == term) || (&count);

   // Load has priority; increment holds at all-ones.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (inc && !(&count))
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot/run sequencer: optional register-file seed, program load into
// instruction memory, timed CPU run, then halt.
// Optional feature macro: BOOT_RF_SEED_EN (adds the SEED state).
module cpu_boot_ctrl
   import cpu_boot_ctrl_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int IMEM_DEPTH = DEF_IMEM_DEPTH,
   parameter int ADDR_W     = $clog2(IMEM_DEPTH),
   parameter int NUM_REGS   = 32,
   parameter int RUN_CYCLES = 15,
   parameter int CNT_W      = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              rf_we,
   output logic [4:0]        rf_addr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  cycle_count
);

   state_t            state;
   logic [ADDR_W-1:0] wptr;
   logic              hs;
   logic              start_ok;
   logic              run_load;
   logic              run_inc;
   logic              run_term;

   assign hs       = load_valid && load_ready;
   assign start_ok = start && (state == ST_IDLE || state == ST_HALT);
   // Clear the timer on a new boot, preload 1 as RUN is entered.
   assign run_load = start_ok || (state == ST_LOAD && hs && load_last);
   assign run_inc  = (state == ST_RUN) && !run_term;

   boot_run_counter #(.CNT_W(CNT_W)) u_run_cnt (
      .clock    (clock),
      .reset    (reset),
      .load     (run_load),
      .load_val ((state == ST_LOAD) ? CNT_W'(1) : CNT_W'(0)),
      .inc      (run_inc),
      .term     (CNT_W'(RUN_CYCLES)),
      .count    (cycle_count),
      .at_term  (run_term)
   );

`ifdef BOOT_RF_SEED_EN
   logic              rf_we_q;
   logic [4:0]        rf_addr_q;
   logic [DATA_W-1:0] rf_wdata_q;
   logic              seed_term;
   logic [CNT_W-1:0]  seed_idx;

   boot_run_counter #(.CNT_W(CNT_W)) u_seed_cnt (
      .clock    (clock),
      .reset    (reset),
      .load     (start_ok),
      .load_val (CNT_W'(0)),
      .inc      (state == ST_SEED && !seed_term),
      .term     (CNT_W'(NUM_REGS - 1)),
      .count    (seed_idx),
      .at_term  (seed_term)
   );

   assign rf_we    = rf_we_q;
   assign rf_addr  = rf_addr_q;
   assign rf_wdata = rf_wdata_q;
`else
   assign rf_we    = 1'b0;
   assign rf_addr  = 5'd0;
   assign rf_wdata = '0;
`endif

   // Sequencer FSM; every output is registered for the state being entered.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         wptr       <= '0;
         load_ready <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_reset  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
`ifdef BOOT_RF_SEED_EN
         rf_we_q    <= 1'b0;
         rf_addr_q  <= 5'd0;
         rf_wdata_q <= '0;
`endif
      end else begin
         imem_we <= 1'b0;
`ifdef BOOT_RF_SEED_EN
         rf_we_q <= 1'b0;
`endif
         case (state)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  err  <= 1'b0;
                  done <= 1'b0;
                  busy <= 1'b1;
                  wptr <= '0;
`ifdef BOOT_RF_SEED_EN
                  state      <= ST_SEED;
                  rf_we_q    <= 1'b1;
                  rf_addr_q  <= 5'd0;
                  rf_wdata_q <= '0;
`else
                  state      <= ST_LOAD;
                  load_ready <= 1'b1;
`endif
               end
            end
`ifdef BOOT_RF_SEED_EN
            ST_SEED: begin
               if (seed_term) begin
                  state      <= ST_LOAD;
                  load_ready <= 1'b1;
               end else begin
                  rf_we_q    <= 1'b1;
                  rf_addr_q  <= rf_addr_q + 5'd1;
                  rf_wdata_q <= rf_wdata_q + DATA_W'(1);
               end
            end
`endif
            ST_LOAD: begin
               if (hs) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= wptr;
                  imem_wdata <= load_data;
                  wptr       <= wptr + ADDR_W'(1);
                  if (load_last) begin
                     state      <= ST_RUN;
                     load_ready <= 1'b0;
                     cpu_reset  <= 1'b0;
                  end else if (wptr == ADDR_W'(IMEM_DEPTH - 1)) begin
                     state      <= ST_HALT;
                     load_ready <= 1'b0;
                     busy       <= 1'b0;
                     err        <= 1'b1;
                     done       <= 1'b0;
                  end
               end
            end
            ST_RUN: begin
               if (run_term) begin
                  state     <= ST_HALT;
                  cpu_reset <= 1'b1;
                  busy      <= 1'b0;
                  done      <= ~err;
               end
            end
            default: begin
               state      <= ST_IDLE;
               load_ready <= 1'b0;
               cpu_reset  <= 1'b1;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed bench for cpu_boot_ctrl: a default instance (depth 32, 15-cycle
// run) and a depth-4 / 3-cycle instance driven by the same stimulus.
module tb_cpu_boot_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        load_valid = 1'b0;
   logic [31:0] load_data = '0;
   logic        load_last = 1'b0;

   logic        load_ready, imem_we, rf_we, cpu_reset, busy, done, err;
   logic [4:0]  imem_addr, rf_addr;
   logic [31:0] imem_wdata, rf_wdata;
   logic [15:0] cycle_count;

   logic        load_ready4, imem_we4, rf_we4, cpu_reset4, busy4, done4, err4;
   logic [1:0]  imem_addr4;
   logic [4:0]  rf_addr4;
   logic [31:0] imem_wdata4, rf_wdata4;
   logic [15:0] cycle_count4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   cpu_boot_ctrl dut (
      .clock(clock), .reset(reset), .start(start),
      .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
      .load_ready(load_ready), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .rf_we(rf_we), .rf_addr(rf_addr),
      .rf_wdata(rf_wdata), .cpu_reset(cpu_reset), .busy(busy), .done(done),
      .err(err), .cycle_count(cycle_count)
   );

   cpu_boot_ctrl #(.IMEM_DEPTH(4), .RUN_CYCLES(3)) dut4 (
      .clock(clock), .reset(reset), .start(start),
      .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
      .load_ready(load_ready4), .imem_we(imem_we4), .imem_addr(imem_addr4),
      .imem_wdata(imem_wdata4), .rf_we(rf_we4), .rf_addr(rf_addr4),
      .rf_wdata(rf_wdata4), .cpu_reset(cpu_reset4), .busy(busy4), .done(done4),
      .err(err4), .cycle_count(cycle_count4)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Walk through the seed phase when it exists, checking the rf writes.
   task automatic seed_phase();
`ifdef BOOT_RF_SEED_EN
      for (int i = 0; i < 32; i++) begin
         chk("seed_we", rf_we, 1);
         chk("seed_addr", rf_addr, i);
         chk("seed_data", rf_wdata, i);
         chk("seed_ready", load_ready, 0);
         step();
      end
`endif
      chk("rf_we_idle", rf_we, 0);
      chk("ready_in_load", load_ready, 1);
   endtask

   logic [31:0] prog [4];
   int lows;

   initial begin
      prog[0] = 32'h20100009;
      prog[1] = 32'h00000000;
      prog[2] = 32'h00000000;
      prog[3] = 32'hAC100004;

      // Reset state
      step(); step();
      chk("rst_cpu_reset", cpu_reset, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_ready", load_ready, 0);
      chk("rst_imem_we", imem_we, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_count", cycle_count, 0);
      reset = 1'b0;
      step();
      chk("idle_ready", load_ready, 0);

      // Boot: seed (if built) then load 4 words with valid held high
      pulse_start();
      chk("boot_busy", busy, 1);
      seed_phase();
      load_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         load_data = prog[i];
         load_last = (i == 3);
         start     = (i == 1);   // ignored while loading
         step();
         start = 1'b0;
         chk("load_we", imem_we, 1);
         chk("load_addr", imem_addr, i);
         chk("load_data", imem_wdata, prog[i]);
         chk("load_cpu_reset", cpu_reset, (i == 3) ? 0 : 1);
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      chk("run_ready", load_ready, 0);
      chk("run_count1", cycle_count, 1);
      chk("d4_last_at_top_runs", cpu_reset4, 0);

      // Run timing: count cycles with cpu_reset low
      lows = 1;
      for (int k = 0; k < 40; k++) begin
         step();
         if (cpu_reset) break;
         lows++;
      end
      chk("run_len", lows, 15);
      chk("halt_count", cycle_count, 15);
      chk("halt_done", done, 1);
      chk("halt_busy", busy, 0);
      chk("halt_err", err, 0);
      chk("d4_done", done4, 1);
      chk("d4_count", cycle_count4, 3);

      // Restart from HALT, then load with valid toggling every cycle
      pulse_start();
      chk("restart_done", done, 0);
      chk("restart_busy", busy, 1);
      chk("restart_count", cycle_count, 0);
      seed_phase();
      for (int j = 0; j < 3; j++) begin
         load_valid = 1'b0;
         load_data  = 32'hDEAD0000 | 32'(j);
         step();
         chk("stall_we", imem_we, 0);
         load_valid = 1'b1;
         load_last  = (j == 2);
         step();
         chk("bp_we", imem_we, 1);
         chk("bp_addr", imem_addr, j);
         chk("bp_data", imem_wdata, 32'hDEAD0000 | 32'(j));
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      chk("bp_run", cpu_reset, 0);
      step(); step();
      chk("bp_count", cycle_count, 3);

      // Asynchronous abort mid-run, away from any clock edge
      #2 reset = 1'b1;
      #1;
      chk("abort_cpu_reset", cpu_reset, 1);
      chk("abort_busy", busy, 0);
      chk("abort_count", cycle_count, 0);
      chk("abort_imem_we", imem_we, 0);
      step();
      reset = 1'b0;
      step();

      // Overflow on the depth-4 instance: 4 words, no load_last
      pulse_start();
      seed_phase();
      load_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         load_data = 32'h100 + 32'(i);
         step();
         chk("ovf_we", imem_we4, 1);
         chk("ovf_addr", imem_addr4, i);
         chk("ovf_data", imem_wdata4, 32'h100 + 32'(i));
      end
      load_valid = 1'b0;
      chk("ovf_err", err4, 1);
      chk("ovf_done", done4, 0);
      chk("ovf_busy", busy4, 0);
      chk("ovf_ready", load_ready4, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("ovf_cpu_held", cpu_reset4, 1);
         chk("ovf_no_write", imem_we4, 0);
      end
      chk("ovf_err_sticky", err4, 1);

      // Restart clears the error
      pulse_start();
      chk("ovf_restart_err", err4, 0);
      chk("ovf_restart_done", done4, 0);
      chk("ovf_restart_busy", busy4, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
